e_gpu_conf_regs: RTL

- OBI responder for the host-side configuration port `conf_regs_req`/`conf_regs_rsp` of `e_gpu`.
- Holds the launch registers: enable, start, kernel PC, argument base, group count and status.
- Drives the start/enable controls toward `controller_i`.
- Captures kernel completion (`cu_end`) into a sticky done flag and an optional interrupt.

---
 rtl/e_gpu_conf_regs.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/e_gpu_conf_regs.sv
// e_gpu_conf_regs: host-side OBI configuration responder for e_gpu.
// Holds the launch registers (CTRL, START, STATUS, KERNEL_PC, ARGS_BASE,
// NUM_GROUPS), drives the enable/start controls toward the controller and
// latches kernel completion into a sticky DONE flag with an optional interrupt.
// Optional feature: define E_GPU_CONF_CYCLE_CNT_EN to add the read-only
// CYCLES counter at offset 0x18 (counts cycles spent in RUN).
module e_gpu_conf_regs #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter logic [31:0] ARGS_RESET = 32'h0001_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  conf_regs_req_req,
    input  logic                  conf_regs_req_we,
    input  logic [3:0]            conf_regs_req_be,
    input  logic [ADDR_WIDTH-1:0] conf_regs_req_addr,
    input  logic [31:0]           conf_regs_req_wdata,
    output logic                  conf_regs_rsp_gnt,
    output logic                  conf_regs_rsp_rvalid,
    output logic [31:0]           conf_regs_rsp_rdata,
    input  logic                  cu_end_i,
    output logic                  gpu_en_o,
    output logic                  start_o,
    output logic [31:0]           kernel_pc_o,
    output logic [31:0]           args_base_o,
    output logic [15:0]           num_groups_o,
    output logic                  irq_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_START  = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_PC     = 3'd3;
    localparam logic [2:0] OFF_ARGS   = 3'd4;
    localparam logic [2:0] OFF_GROUPS = 3'd5;
    localparam logic [2:0] OFF_CYCLES = 3'd6;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic [31:0] kernel_pc_q, kernel_pc_d;
    logic [31:0] args_base_q, args_base_d;
    logic [15:0] num_groups_q, num_groups_d;
    logic        cu_prev_q, cu_prev_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;
`ifdef E_GPU_CONF_CYCLE_CNT_EN
    logic [31:0] cycles_q, cycles_d;
`endif

    logic [2:0]  word;
    logic        wr;
    logic        rd;
    logic        start_wr;
    logic        done_w1c;
    logic        cu_rise;
    logic        done_set;
    logic        busy;
    logic [31:0] rd_val;
    logic [31:0] groups_merged;
    logic        unused_addr_bits;

    // Byte-lane merge of new write data over an existing register value.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    assign word             = conf_regs_req_addr[4:2];
    assign unused_addr_bits = ^{conf_regs_req_addr[ADDR_WIDTH-1:5], conf_regs_req_addr[1:0]};
    assign wr               = conf_regs_req_req & conf_regs_req_we;
    assign rd               = conf_regs_req_req & ~conf_regs_req_we;
    assign start_wr         = wr & (word == OFF_START) & conf_regs_req_be[0] & conf_regs_req_wdata[0];
    assign done_w1c         = wr & (word == OFF_STATUS) & conf_regs_req_be[0] & conf_regs_req_wdata[1];
    assign cu_rise          = cu_end_i & ~cu_prev_q;
    assign busy             = (state_q != IDLE);
    assign groups_merged    = be_merge({16'h0000, num_groups_q}, conf_regs_req_wdata, conf_regs_req_be);

    // Read mux: the value returned is the register contents at grant time.
    always_comb begin
        rd_val = 32'h0000_0000;
        case (word)
            OFF_CTRL:   rd_val = {30'd0, irq_en_q, en_q};
            OFF_STATUS: rd_val = {30'd0, done_q, busy};
            OFF_PC:     rd_val = kernel_pc_q;
            OFF_ARGS:   rd_val = args_base_q;
            OFF_GROUPS: rd_val = {16'h0000, num_groups_q};
`ifdef E_GPU_CONF_CYCLE_CNT_EN
            OFF_CYCLES: rd_val = cycles_q;
`else
            OFF_CYCLES: rd_val = 32'h0000_0000;
`endif
            default:    rd_val = 32'h0000_0000;
        endcase
    end

    // Next-state logic: register writes, launch FSM, DONE/IRQ and response.
    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        irq_en_d     = irq_en_q;
        kernel_pc_d  = kernel_pc_q;
        args_base_d  = args_base_q;
        num_groups_d = num_groups_q;
        done_set     = 1'b0;

        if (wr) begin
            case (word)
                OFF_CTRL: begin
                    if (conf_regs_req_be[0]) begin
                        en_d     = conf_regs_req_wdata[0];
                        irq_en_d = conf_regs_req_wdata[1];
                    end
                end
                OFF_PC:     kernel_pc_d  = be_merge(kernel_pc_q, conf_regs_req_wdata, conf_regs_req_be);
                OFF_ARGS:   args_base_d  = be_merge(args_base_q, conf_regs_req_wdata, conf_regs_req_be);
                OFF_GROUPS: num_groups_d = groups_merged[15:0];
                default:    ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_wr && en_q) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = en_d ? RUN : IDLE;
            end
            RUN: begin
                if (cu_rise) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end
                if (!en_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done_set) begin
            done_d = 1'b1;
        end else if (done_w1c) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        cu_prev_d = cu_end_i;
        start_d   = (state_d == LAUNCH);
        irq_d     = done_d & irq_en_d;
        rvalid_d  = conf_regs_req_req;
        rdata_d   = rd ? rd_val : 32'h0000_0000;

`ifdef E_GPU_CONF_CYCLE_CNT_EN
        if (state_q == IDLE && state_d == LAUNCH) begin
            cycles_d = 32'h0000_0000;
        end else if (state_q == RUN) begin
            cycles_d = cycles_q + 32'd1;
        end else begin
            cycles_d = cycles_q;
        end
`endif
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            kernel_pc_q  <= PC_RESET;
            args_base_q  <= ARGS_RESET;
            num_groups_q <= 16'h0000;
            cu_prev_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            start_q      <= 1'b0;
            irq_q        <= 1'b0;
`ifdef E_GPU_CONF_CYCLE_CNT_EN
            cycles_q     <= 32'h0000_0000;
`endif
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            kernel_pc_q  <= kernel_pc_d;
            args_base_q  <= args_base_d;
            num_groups_q <= num_groups_d;
            cu_prev_q    <= cu_prev_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            start_q      <= start_d;
            irq_q        <= irq_d;
`ifdef E_GPU_CONF_CYCLE_CNT_EN
            cycles_q     <= cycles_d;
`endif
        end
    end

    assign conf_regs_rsp_gnt    = conf_regs_req_req;
    assign conf_regs_rsp_rvalid = rvalid_q;
    assign conf_regs_rsp_rdata  = rdata_q;
    assign gpu_en_o             = en_q;
    assign start_o              = start_q;
    assign kernel_pc_o          = kernel_pc_q;
    assign args_base_o          = args_base_q;
    assign num_groups_o         = num_groups_q;
    assign irq_o                = irq_q;

endmodule
